dff_response_checker: RTL and testbench

- Observing end of the D flip-flop stimulus path: samples the stimulus applied to the flip-flop (dut_d) and its output (dut_q) on every rising clk.
- Predicts q from the previous edge's d and counts checked samples and mismatches.
- Raises done/pass after a fixed number of checks.
- Used in benches alongside the d stimulus generator; written synthesizable so it can also sit on-chip as a self-test monitor.

---
 rtl/dff_response_checker.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dff_response_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dff_response_checker
// Purpose  : Observing end of a D flip-flop test path. Samples the flip-flop
//            input (dut_d) and output (dut_q) on every rising clk, predicts q
//            from the previous edge's d, counts compares and mismatches, and
//            raises done/pass after NUM_CHECKS compares. Synthesizable, so it
//            can also serve as an on-chip self-test monitor.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   NUM_CHECKS : compares to perform before done (0 = done straight after
//                warm-up, with pass = 1)
//   CNT_W      : width of check_count; must hold NUM_CHECKS
//   ERR_W      : width of err_count; saturates at all-ones
//   WARMUP     : capture-only edges after (re)arm, valid range 1..15
// Ports:
//   clk            in   1      rising-edge clock
//   rst            in   1      asynchronous active-high reset
//   en             in   1      level enable, sampled at the clock edge
//   dut_d          in   1      d value presented to the flip-flop
//   dut_q          in   1      q output of the flip-flop
//   check_count    out  CNT_W  compares performed
//   err_count      out  ERR_W  mismatches seen, saturating
//   error          out  1      sticky, set on the first mismatch
//   done           out  1      NUM_CHECKS compares complete
//   pass           out  1      done with err_count == 0
// Optional (macro FIRST_FAIL_LOG_EN defined):
//   first_fail_idx out  CNT_W  0-based index of the first mismatching compare
//   first_fail_exp out  1      expected q at that compare
// ============================================================================
module dff_response_checker #(
    parameter int NUM_CHECKS = 5,
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 8,
    parameter int WARMUP     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dut_d,
    input  logic             dut_q,
    output logic [CNT_W-1:0] check_count,
    output logic [ERR_W-1:0] err_count,
    output logic             error,
    output logic             done,
    output logic             pass
`ifdef FIRST_FAIL_LOG_EN
    ,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [0:0]       first_fail_exp
);
`else
);
`endif

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_warmup = 3'd1;
    localparam logic [2:0] c_st_check  = 3'd2;
    localparam logic [2:0] c_st_pause  = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic [3:0]       c_warm_load   = 4'(WARMUP);
    localparam logic [3:0]       c_warm_one    = 4'd1;
    localparam logic [CNT_W-1:0] c_num_checks  = CNT_W'(NUM_CHECKS);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [ERR_W-1:0] c_err_one     = ERR_W'(1);
    localparam logic [ERR_W-1:0] c_err_max     = '1;
    localparam bit               c_zero_checks = (NUM_CHECKS == 0);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_check_count;
    logic [ERR_W-1:0] r_err_count;
    logic             r_error;
    logic             r_done;
    logic             r_pass;
    logic             r_d_prev;
    logic [3:0]       r_warm;

    // ------------------------------------------------------------------------
    // Next-state / next-value wires
    // ------------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_check_count_nxt;
    logic [ERR_W-1:0] w_err_count_nxt;
    logic             w_error_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic             w_d_prev_nxt;
    logic [3:0]       w_warm_nxt;

    logic             w_arm;
    logic             w_compare;
    logic             w_mismatch;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ERR_W-1:0] w_err_inc;

    // The edge that leaves IDLE clears the run; the first-fail log uses it too.
    assign w_arm     = (r_state == c_st_idle) && en;
    assign w_compare = (r_state == c_st_check) && en;

    // Case-inequality so that an X or Z on dut_q is scored as a mismatch.
    assign w_mismatch = (dut_q !== r_d_prev);

    assign w_cnt_inc = r_check_count + c_cnt_one;
    assign w_err_inc = (r_err_count == c_err_max) ? r_err_count
                                                  : r_err_count + c_err_one;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_check_count_nxt = r_check_count;
        w_err_count_nxt   = r_err_count;
        w_error_nxt       = r_error;
        w_done_nxt        = r_done;
        w_pass_nxt        = r_pass;
        w_d_prev_nxt      = r_d_prev;
        w_warm_nxt        = r_warm;

        case (r_state)
            c_st_idle: begin
                if (w_arm) begin
                    w_state_nxt       = c_st_warmup;
                    w_check_count_nxt = '0;
                    w_err_count_nxt   = '0;
                    w_error_nxt       = 1'b0;
                    w_done_nxt        = 1'b0;
                    w_pass_nxt        = 1'b0;
                    w_warm_nxt        = c_warm_load;
                    w_d_prev_nxt      = dut_d;
                end
            end

            c_st_warmup: begin
                if (!en) begin
                    w_state_nxt = c_st_pause;
                end else begin
                    w_d_prev_nxt = dut_d;
                    if (r_warm <= c_warm_one) begin
                        // With nothing to compare the run completes here.
                        if (c_zero_checks) begin
                            w_state_nxt = c_st_done;
                            w_done_nxt  = 1'b1;
                            w_pass_nxt  = (r_err_count == '0);
                        end else begin
                            w_state_nxt = c_st_check;
                        end
                    end else begin
                        w_warm_nxt = r_warm - c_warm_one;
                    end
                end
            end

            c_st_check: begin
                if (!en) begin
                    w_state_nxt = c_st_pause;
                end else begin
                    w_check_count_nxt = w_cnt_inc;
                    w_d_prev_nxt      = dut_d;
                    if (w_mismatch) begin
                        w_err_count_nxt = w_err_inc;
                        w_error_nxt     = 1'b1;
                    end
                    if (w_cnt_inc == c_num_checks) begin
                        w_state_nxt = c_st_done;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_count_nxt == '0);
                    end
                end
            end

            c_st_pause: begin
                // d_prev is stale after a pause, so re-warm before comparing;
                // the run's counters carry on untouched.
                if (en) begin
                    w_state_nxt  = c_st_warmup;
                    w_warm_nxt   = c_warm_load;
                    w_d_prev_nxt = dut_d;
                end
            end

            c_st_done: begin
                if (!en) begin
                    w_state_nxt = c_st_idle;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_check_count <= '0;
            r_err_count   <= '0;
            r_error       <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_d_prev      <= 1'b0;
            r_warm        <= '0;
        end else begin
            r_check_count <= w_check_count_nxt;
            r_err_count   <= w_err_count_nxt;
            r_error       <= w_error_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_d_prev      <= w_d_prev_nxt;
            r_warm        <= w_warm_nxt;
        end
    end

    assign check_count = r_check_count;
    assign err_count   = r_err_count;
    assign error       = r_error;
    assign done        = r_done;
    assign pass        = r_pass;

`ifdef FIRST_FAIL_LOG_EN
    // ------------------------------------------------------------------------
    // First-failure log: captured on the compare that first sets error
    // ------------------------------------------------------------------------
    logic             w_first_fail;
    logic [CNT_W-1:0] r_first_fail_idx;
    logic             r_first_fail_exp;

    assign w_first_fail = w_compare && w_mismatch && !r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_fail_idx <= '0;
            r_first_fail_exp <= 1'b0;
        end else if (w_arm) begin
            r_first_fail_idx <= '0;
            r_first_fail_exp <= 1'b0;
        end else if (w_first_fail) begin
            r_first_fail_idx <= r_check_count;
            r_first_fail_exp <= r_d_prev;
        end
    end

    assign first_fail_idx = r_first_fail_idx;
    assign first_fail_exp = r_first_fail_exp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_response_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dff_response_checker
// Purpose  : Directed self-checking bench for dff_response_checker. A
//            behavioural flip-flop supplies dut_q; its output can be replaced
//            by a constant 0, its inverse, or a single corrupted sample.
//            Extra instances cover err_count saturation and NUM_CHECKS = 0.
//            Optional FIRST_FAIL_LOG_EN outputs are checked when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_response_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       en_sat;
    logic       d;
    logic       corrupt;
    logic [1:0] qmode;
    logic       q_ff;
    logic       q_drv;
    logic       q_inv;

    int n_cmp = 0;
    int n_bad = 0;

    // main instance outputs
    logic [7:0] check_count;
    logic [7:0] err_count;
    logic       error;
    logic       done;
    logic       pass;

    // saturation instance outputs (ERR_W = 2, NUM_CHECKS = 6)
    logic [7:0] s_check_count;
    logic [1:0] s_err_count;
    logic       s_error;
    logic       s_done;
    logic       s_pass;

    // zero-check instance outputs (NUM_CHECKS = 0)
    logic [7:0] z_check_count;
    logic [7:0] z_err_count;
    logic       z_error;
    logic       z_done;
    logic       z_pass;

`ifdef FIRST_FAIL_LOG_EN
    logic [7:0] ff_idx;
    logic [0:0] ff_exp;
    logic [7:0] s_ff_idx;
    logic [0:0] s_ff_exp;
    logic [7:0] z_ff_idx;
    logic [0:0] z_ff_exp;
`endif

    always #5 clk = ~clk;

    // Reference flip-flop driven by the same d as the checker sees.
    always @(posedge clk) q_ff <= d;

    always_comb begin
        q_drv = q_ff ^ corrupt;
        case (qmode)
            2'd1:    q_drv = 1'b0;
            2'd2:    q_drv = ~q_ff;
            default: q_drv = q_ff ^ corrupt;
        endcase
    end

    assign q_inv = ~q_ff;

    dff_response_checker #(
        .NUM_CHECKS(5), .CNT_W(8), .ERR_W(8), .WARMUP(1)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .dut_d(d), .dut_q(q_drv),
        .check_count(check_count), .err_count(err_count),
        .error(error), .done(done), .pass(pass)
`ifdef FIRST_FAIL_LOG_EN
        , .first_fail_idx(ff_idx), .first_fail_exp(ff_exp)
`endif
    );

    dff_response_checker #(
        .NUM_CHECKS(6), .CNT_W(8), .ERR_W(2), .WARMUP(1)
    ) u_sat (
        .clk(clk), .rst(rst), .en(en_sat), .dut_d(d), .dut_q(q_inv),
        .check_count(s_check_count), .err_count(s_err_count),
        .error(s_error), .done(s_done), .pass(s_pass)
`ifdef FIRST_FAIL_LOG_EN
        , .first_fail_idx(s_ff_idx), .first_fail_exp(s_ff_exp)
`endif
    );

    dff_response_checker #(
        .NUM_CHECKS(0), .CNT_W(8), .ERR_W(8), .WARMUP(1)
    ) u_zero (
        .clk(clk), .rst(rst), .en(en_sat), .dut_d(d), .dut_q(q_drv),
        .check_count(z_check_count), .err_count(z_err_count),
        .error(z_error), .done(z_done), .pass(z_pass)
`ifdef FIRST_FAIL_LOG_EN
        , .first_fail_idx(z_ff_idx), .first_fail_exp(z_ff_exp)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 2 ns after it.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // n edges; d toggles right after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            d = ~d;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; en_sat = 1'b0; d = 1'b0; corrupt = 1'b0; qmode = 2'd0;
        #3;
        chk("rst_count", 32'(check_count), 32'd0);
        chk("rst_err",   32'(err_count),   32'd0);
        chk("rst_error", 32'(error),       32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_pass",  32'(pass),        32'd0);
        chk("rst_sat_err", 32'(s_err_count), 32'd0);
        chk("rst_zero_done", 32'(z_done), 32'd0);
        cyc();
        rst = 1'b0;

        // --- correct flip-flop: 1 warm-up + 5 compares --------------------
        d = 1'b1; en = 1'b1;
        run(6);
        chk("ok_count4", 32'(check_count), 32'd4);
        chk("ok_notdone", 32'(done), 32'd0);
        run(1);
        chk("ok_done",  32'(done),        32'd1);
        chk("ok_pass",  32'(pass),        32'd1);
        chk("ok_count", 32'(check_count), 32'd5);
        chk("ok_err",   32'(err_count),   32'd0);
        chk("ok_error", 32'(error),       32'd0);
        run(1);
        chk("ok_count_cap", 32'(check_count), 32'd5);

        // --- q stuck at 0: mismatches on compares 0, 2, 4 ------------------
        en = 1'b0; run(1);
        qmode = 2'd1; d = 1'b0; en = 1'b1;
        run(1);
        chk("s0_arm_count", 32'(check_count), 32'd0);
        chk("s0_arm_done",  32'(done),        32'd0);
        run(2);
        chk("s0_err1",   32'(err_count), 32'd1);
        chk("s0_error1", 32'(error),     32'd1);
        run(4);
        chk("s0_err",   32'(err_count),   32'd3);
        chk("s0_error", 32'(error),       32'd1);
        chk("s0_done",  32'(done),        32'd1);
        chk("s0_pass",  32'(pass),        32'd0);
        chk("s0_count", 32'(check_count), 32'd5);

        // --- async reset between edges after 2 compares --------------------
        en = 1'b0; run(1);
        qmode = 2'd2; en = 1'b1;
        run(4);
        chk("ar_pre_count", 32'(check_count), 32'd2);
        chk("ar_pre_err",   32'(err_count),   32'd2);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_count", 32'(check_count), 32'd0);
        chk("ar_err",   32'(err_count),   32'd0);
        chk("ar_error", 32'(error),       32'd0);
        chk("ar_done",  32'(done),        32'd0);
        chk("ar_pass",  32'(pass),        32'd0);
        #1;
        rst = 1'b0; qmode = 2'd0;
        run(7);
        chk("ar_rerun_done", 32'(done), 32'd1);
        chk("ar_rerun_pass", 32'(pass), 32'd1);

        // --- pause after 2 compares for 3 edges ----------------------------
        en = 1'b0; run(1);
        en = 1'b1;
        run(4);
        chk("pz_count2", 32'(check_count), 32'd2);
        en = 1'b0;
        run(1);
        chk("pz_hold1", 32'(check_count), 32'd2);
        run(2);
        chk("pz_hold3", 32'(check_count), 32'd2);
        chk("pz_notdone", 32'(done), 32'd0);
        en = 1'b1;
        run(2);
        chk("pz_rewarm", 32'(check_count), 32'd2);
        run(1);
        chk("pz_count3", 32'(check_count), 32'd3);
        run(2);
        chk("pz_count", 32'(check_count), 32'd5);
        chk("pz_done",  32'(done),        32'd1);
        chk("pz_pass",  32'(pass),        32'd1);

        // --- single corrupted q on compare 3 (expected 1) ------------------
        en = 1'b0; run(1);
        qmode = 2'd0; d = 1'b1; en = 1'b1;
        run(5);
        chk("ff_pre_err", 32'(err_count), 32'd0);
        corrupt = 1'b1;
        run(1);
        corrupt = 1'b0;
        chk("ff_err",   32'(err_count),   32'd1);
        chk("ff_error", 32'(error),       32'd1);
        chk("ff_count", 32'(check_count), 32'd4);
`ifdef FIRST_FAIL_LOG_EN
        chk("ff_idx", 32'(ff_idx), 32'd3);
        chk("ff_exp", 32'(ff_exp), 32'd1);
`endif
        run(1);
        chk("ff_done",     32'(done),      32'd1);
        chk("ff_pass",     32'(pass),      32'd0);
        chk("ff_err_end",  32'(err_count), 32'd1);
`ifdef FIRST_FAIL_LOG_EN
        chk("ff_idx_hold", 32'(ff_idx), 32'd3);
`endif

        // --- saturation (ERR_W=2) and NUM_CHECKS=0 -------------------------
        en = 1'b0;
        en_sat = 1'b1;
        run(1);
        chk("z_notdone", 32'(z_done), 32'd0);
        run(1);
        chk("z_done",  32'(z_done),        32'd1);
        chk("z_pass",  32'(z_pass),        32'd1);
        chk("z_count", 32'(z_check_count), 32'd0);
        run(3);
        chk("sat_err3",  32'(s_err_count),   32'd3);
        chk("sat_count", 32'(s_check_count), 32'd3);
        run(1);
        chk("sat_hold",  32'(s_err_count), 32'd3);
        chk("sat_error", 32'(s_error),     32'd1);
        run(2);
        chk("sat_done",      32'(s_done),        32'd1);
        chk("sat_pass",      32'(s_pass),        32'd0);
        chk("sat_count_end", 32'(s_check_count), 32'd6);
        chk("sat_err_end",   32'(s_err_count),   32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
